fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch unit: consumer side of the program counter. It samples `PC`, issues a word read to instruction memory over a req/ack handshake, and holds the returned instruction for decode under a valid/ready handshake. It tells the PC register when to advance via `pc_en`, and flushes in-flight work when `PC_select` signals a jump/branch redirect.

## Interface
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: instruction width.
- `NOP`, 32'h00000013: value driven on `instr` when nothing is valid (addi x0,x0,0).

Ports:
- `clk`  in  1  system clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `PC`  in  ADDR_W  current program counter.
- `PC_select`  in  1  redirect/flush; PC loads ALU target this edge.
- `pc_en`  out  1  one-cycle pulse; PC register advances (PC+4) when high.
- `mem_req`  out  1  read request to instruction memory.
- `mem_addr`  out  ADDR_W  read address, word aligned.
- `mem_ack`  in  1  memory returns data this cycle.
- `mem_rdata`  in  DATA_W  read data, valid when `mem_ack`.
- `instr`  out  DATA_W  fetched instruction.
- `instr_pc`  out  ADDR_W  address `instr` was fetched from.
- `instr_valid`  out  1  `instr`/`instr_pc` valid for decode.
- `instr_ready`  in  1  decode accepts this cycle.
- `fetch_misalign`  out  1  sticky misaligned-PC fault.

## Operation
- States: IDLE, REQ, FULL, ERR.
- IDLE: entered only from reset; next edge -> REQ, latching `PC` into `mem_addr`.
- REQ: `mem_req`=1, `mem_addr` stable until ack (never withdrawn or changed mid-request).
  - `mem_ack` and no drop pending: capture `mem_rdata`->`instr`, `mem_addr`->`instr_pc`, set `instr_valid`, pulse `pc_en`, -> FULL.
  - `mem_ack` with drop pending: discard data, clear drop, re-latch `PC`, stay REQ (new request next cycle).
  - `PC_select` while waiting: set drop flag; request completes, then is discarded.
  - `PC_select` and `mem_ack` same cycle: data discarded, no `pc_en`.
- FULL: hold outputs until `instr_valid && instr_ready`; then clear valid, latch `PC`, -> REQ.
  - `PC_select` in FULL: clear `instr_valid`, `instr`<=NOP, latch `PC` next cycle, -> REQ; redirect wins over simultaneous `instr_ready`.
- Alignment: on every latch, if `PC[1:0]`!=0 -> ERR instead of REQ; `fetch_misalign`=1, no request issued.
- ERR: held until `PC_select`; then clear `fetch_misalign`, latch `PC` (re-checked), -> REQ or ERR.
- `pc_en` never asserted in the same cycle as `PC_select`.

## Timing
- Reset (async assert): state IDLE, `mem_req`=0, `mem_addr`=0, `instr`=NOP, `instr_pc`=0, `instr_valid`=0, `pc_en`=0, `fetch_misalign`=0, drop flag=0. Deassertion synchronous to `clk`.
- First `mem_req` in cycle 2 after reset release.
- `mem_ack` sampled at edge N -> `instr_valid`=1 and `pc_en`=1 in cycle N+1; `pc_en` low in N+2.
- Accept at edge M -> `mem_req` high in cycle M+1 at the advanced PC.
- Peak throughput with zero-wait memory: one instruction per 2 cycles.
- `mem_ack` outside REQ ignored.
- Reset mid-request: request abandoned immediately; memory must tolerate dropped req.

## Structure
- Shared package `fetch_pkg`: state encoding (IDLE/REQ/FULL/ERR), `NOP` constant, `ADDR_W`/`DATA_W` defaults.
- Single module; optional sub-module `fetch_ireg` (instruction/PC holding register with valid, load, clear) reusable by later pipeline stages.

## Test plan
- Reset, PC=0x0, 1-cycle-latency ack with rdata 0x00500093, `instr_ready`=1 -> `mem_addr`=0x0, `instr`=0x00500093, `instr_pc`=0x0, one `pc_en` pulse, next `mem_addr`=0x4.
- Ack delayed 3 cycles -> `mem_req`/`mem_addr` stable all 3 cycles, `instr_valid` low until cycle after ack.
- `instr_ready`=0 for 4 cycles in FULL -> `instr`/`instr_pc` held, no new `mem_req`, `pc_en` low.
- `PC_select` pulse while REQ pending, PC becomes 0xA0 -> acked data discarded, no `instr_valid`, next request `mem_addr`=0xA0.
- `PC_select` with `instr_ready` same cycle in FULL, PC becomes 0x200 -> instruction dropped, `instr`=NOP, next `mem_addr`=0x200.
- PC=0x202 -> `fetch_misalign`=1, no `mem_req`; `PC_select` with PC=0x200 -> flag clears, fetch resumes at 0x200.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: state encoding, widths, NOP.
package fetch_pkg;

   localparam int unsigned FETCH_ADDR_W = 32;
   localparam int unsigned FETCH_DATA_W = 32;
   localparam logic [31:0] FETCH_NOP    = 32'h0000_0013;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_FULL = 2'd2,
      ST_ERR  = 2'd3
   } fetch_state_t;

   function automatic logic is_misaligned(input logic [1:0] lsb);
      return lsb != 2'b00;
   endfunction

endpackage

// File: rtl/fetch_ireg.sv
// Instruction/PC holding register with valid; clear drops valid and parks NOP on the data.
module fetch_ireg
   import fetch_pkg::*;
#(
   parameter int unsigned       ADDR_W = FETCH_ADDR_W,
   parameter int unsigned       DATA_W = FETCH_DATA_W,
   parameter logic [DATA_W-1:0] NOP    = DATA_W'(FETCH_NOP)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_load,
   input  logic              i_clear,
   input  logic [DATA_W-1:0] i_instr,
   input  logic [ADDR_W-1:0] i_pc,
   output logic [DATA_W-1:0] o_instr,
   output logic [ADDR_W-1:0] o_pc,
   output logic              o_valid
);

   logic [DATA_W-1:0] r_instr;
   logic [ADDR_W-1:0] r_pc;
   logic              r_valid;

   // Clear has priority so a flush can never be overtaken by a late load.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_instr <= NOP;
         r_pc    <= '0;
         r_valid <= 1'b0;
      end else if (i_clear) begin
         r_instr <= NOP;
         r_valid <= 1'b0;
      end else if (i_load) begin
         r_instr <= i_instr;
         r_pc    <= i_pc;
         r_valid <= 1'b1;
      end
   end

   assign o_instr = r_instr;
   assign o_pc    = r_pc;
   assign o_valid = r_valid;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: latches PC, runs a req/ack memory read, presents the word to decode
// under valid/ready, advances PC via pc_en and flushes on PC_select redirects.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int unsigned       ADDR_W = FETCH_ADDR_W,
   parameter int unsigned       DATA_W = FETCH_DATA_W,
   parameter logic [DATA_W-1:0] NOP    = DATA_W'(FETCH_NOP)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] PC,
   input  logic              PC_select,
   output logic              pc_en,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [DATA_W-1:0] instr,
   output logic [ADDR_W-1:0] instr_pc,
   output logic              instr_valid,
   input  logic              instr_ready,
   output logic              fetch_misalign
);

   fetch_state_t      r_state, w_state_nxt;
   logic              r_mem_req, w_req_nxt;
   logic [ADDR_W-1:0] r_mem_addr, w_addr_nxt;
   logic              r_pc_en, w_pc_en_nxt;
   logic              r_misalign, w_misalign_nxt;
   logic              r_drop, w_drop_nxt;
   logic              r_reload, w_reload_nxt;
   logic              w_load, w_clear, w_latch;
   logic [ADDR_W-1:0] w_latch_addr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_mem_req  <= 1'b0;
         r_mem_addr <= '0;
         r_pc_en    <= 1'b0;
         r_misalign <= 1'b0;
         r_drop     <= 1'b0;
         r_reload   <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_mem_req  <= w_req_nxt;
         r_mem_addr <= w_addr_nxt;
         r_pc_en    <= w_pc_en_nxt;
         r_misalign <= w_misalign_nxt;
         r_drop     <= w_drop_nxt;
         r_reload   <= w_reload_nxt;
      end
   end

   // r_reload: PC is being redirected this edge, so sample it one cycle later with req low.
   always_comb begin
      w_state_nxt    = r_state;
      w_req_nxt      = r_mem_req;
      w_addr_nxt     = r_mem_addr;
      w_pc_en_nxt    = 1'b0;
      w_misalign_nxt = r_misalign;
      w_drop_nxt     = r_drop;
      w_reload_nxt   = r_reload;
      w_load         = 1'b0;
      w_clear        = 1'b0;
      w_latch        = 1'b0;
      w_latch_addr   = PC;

      case (r_state)
         ST_IDLE: begin
            if (PC_select) begin
               w_state_nxt  = ST_REQ;
               w_reload_nxt = 1'b1;
            end else begin
               w_latch = 1'b1;
            end
         end
         ST_REQ: begin
            if (r_reload) begin
               if (!PC_select) begin
                  w_latch      = 1'b1;
                  w_reload_nxt = 1'b0;
               end
            end else if (mem_ack) begin
               if (r_drop || PC_select) begin
                  w_drop_nxt = 1'b0;
                  if (PC_select) begin
                     w_reload_nxt = 1'b1;
                     w_req_nxt    = 1'b0;
                  end else begin
                     w_latch = 1'b1;
                  end
               end else begin
                  w_load      = 1'b1;
                  w_pc_en_nxt = 1'b1;
                  w_req_nxt   = 1'b0;
                  w_state_nxt = ST_FULL;
               end
            end else if (PC_select) begin
               w_drop_nxt = 1'b1;
            end
         end
         ST_FULL: begin
            if (PC_select) begin
               w_clear      = 1'b1;
               w_reload_nxt = 1'b1;
               w_state_nxt  = ST_REQ;
            end else if (instr_ready) begin
               // PC register advances on this same edge while pc_en is still high.
               w_clear      = 1'b1;
               w_latch      = 1'b1;
               w_latch_addr = r_pc_en ? PC + ADDR_W'(4) : PC;
            end
         end
         ST_ERR: begin
            if (PC_select) begin
               w_misalign_nxt = 1'b0;
               w_reload_nxt   = 1'b1;
               w_state_nxt    = ST_REQ;
            end
         end
      endcase

      if (w_latch) begin
         w_addr_nxt = w_latch_addr;
         if (is_misaligned(w_latch_addr[1:0])) begin
            w_state_nxt    = ST_ERR;
            w_req_nxt      = 1'b0;
            w_misalign_nxt = 1'b1;
         end else begin
            w_state_nxt = ST_REQ;
            w_req_nxt   = 1'b1;
         end
      end
   end

   fetch_ireg #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .NOP    (NOP)
   ) u_ireg (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_load  (w_load),
      .i_clear (w_clear),
      .i_instr (mem_rdata),
      .i_pc    (r_mem_addr),
      .o_instr (instr),
      .o_pc    (instr_pc),
      .o_valid (instr_valid)
   );

   // A redirect owns the PC register; the advance pulse yields to it.
   assign pc_en          = r_pc_en & ~PC_select;
   assign mem_req        = r_mem_req;
   assign mem_addr       = r_mem_addr;
   assign fetch_misalign = r_misalign;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: PC register and memory models, directed steps, then random traffic.
module tb_fetch_unit;

   localparam logic [31:0] NOP_I = 32'h0000_0013;

   logic        clk;
   logic        rst_n;
   logic [31:0] PC;
   logic        PC_select;
   logic        pc_en;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ack = 1'b0;
   logic [31:0] mem_rdata = 32'h0;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_valid;
   logic        instr_ready;
   logic        fetch_misalign;

   logic [31:0] tgt;
   logic [31:0] pc_rst;
   int          lat;
   int          wcnt = 0;
   bit          spur;
   int          total;
   int          bad;

   fetch_unit dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .PC             (PC),
      .PC_select      (PC_select),
      .pc_en          (pc_en),
      .mem_req        (mem_req),
      .mem_addr       (mem_addr),
      .mem_ack        (mem_ack),
      .mem_rdata      (mem_rdata),
      .instr          (instr),
      .instr_pc       (instr_pc),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .fetch_misalign (fetch_misalign)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] memf(input logic [31:0] a);
      if (a == 32'h0) return 32'h0050_0093;
      return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
   endfunction

   // Program counter register driven by the fetch unit's controls.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)         PC <= pc_rst;
      else if (PC_select) PC <= tgt;
      else if (pc_en)     PC <= PC + 32'd4;
   end

   // Instruction memory: acks a held request after 'lat' wait cycles; optional stray acks.
   always @(posedge clk) begin
      #1;
      if (!rst_n) begin
         mem_ack = 1'b0;
         wcnt    = 0;
      end else if (mem_ack) begin
         mem_ack = 1'b0;
         wcnt    = 0;
      end else if (mem_req) begin
         if (wcnt >= lat) begin
            mem_ack   = 1'b1;
            mem_rdata = memf(mem_addr);
         end else begin
            wcnt++;
         end
      end else begin
         wcnt = 0;
         if (spur && ($urandom_range(0, 3) == 0)) begin
            mem_ack   = 1'b1;
            mem_rdata = $urandom;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic settle();
      #1;
   endtask

   logic [31:0] exp_pc;
   logic [31:0] prev_addr;
   bit          prev_wait;
   int          ndel;

   initial begin
      rst_n       = 1'b0;
      PC_select   = 1'b0;
      instr_ready = 1'b1;
      tgt         = 32'h0;
      pc_rst      = 32'h0;
      lat         = 1;
      spur        = 1'b0;
      total       = 0;
      bad         = 0;
      ndel        = 0;

      repeat (3) @(posedge clk);
      #2; settle();
      chk("rst_mem_req", 32'(mem_req), 32'd0);
      chk("rst_mem_addr", mem_addr, 32'h0);
      chk("rst_instr", instr, NOP_I);
      chk("rst_instr_pc", instr_pc, 32'h0);
      chk("rst_valid", 32'(instr_valid), 32'd0);
      chk("rst_pc_en", 32'(pc_en), 32'd0);
      chk("rst_misalign", 32'(fetch_misalign), 32'd0);
      rst_n = 1'b1;

      // Basic fetch at PC 0 with a one-wait-cycle memory.
      tick(); settle();
      chk("t1_req", 32'(mem_req), 32'd1);
      chk("t1_addr", mem_addr, 32'h0);
      chk("t1_valid_lo", 32'(instr_valid), 32'd0);
      tick(); settle();
      chk("t1_req_wait", 32'(mem_req), 32'd1);
      chk("t1_pc_en_lo", 32'(pc_en), 32'd0);
      tick(); settle();
      chk("t1_valid", 32'(instr_valid), 32'd1);
      chk("t1_instr", instr, 32'h0050_0093);
      chk("t1_instr_pc", instr_pc, 32'h0);
      chk("t1_pc_en", 32'(pc_en), 32'd1);
      chk("t1_req_done", 32'(mem_req), 32'd0);
      lat = 3;
      tick(); settle();
      chk("t1_pc_en_pulse", 32'(pc_en), 32'd0);
      chk("t1_cleared", instr, NOP_I);
      chk("t1_next_req", 32'(mem_req), 32'd1);
      chk("t1_next_addr", mem_addr, 32'h4);

      // Three wait cycles: request held steady, nothing valid.
      for (int i = 0; i < 3; i++) begin
         tick();
         if (i == 2) instr_ready = 1'b0;
         settle();
         chk("t2_req_hold", 32'(mem_req), 32'd1);
         chk("t2_addr_hold", mem_addr, 32'h4);
         chk("t2_valid_lo", 32'(instr_valid), 32'd0);
      end
      tick(); settle();
      chk("t2_valid", 32'(instr_valid), 32'd1);
      chk("t2_instr", instr, memf(32'h4));
      chk("t2_instr_pc", instr_pc, 32'h4);
      chk("t2_pc_en", 32'(pc_en), 32'd1);

      // Decode stalls: outputs held, no new request.
      for (int i = 0; i < 3; i++) begin
         tick();
         if (i == 2) instr_ready = 1'b1;
         settle();
         chk("t3_valid_hold", 32'(instr_valid), 32'd1);
         chk("t3_instr_hold", instr, memf(32'h4));
         chk("t3_pc_hold", instr_pc, 32'h4);
         chk("t3_pc_en_lo", 32'(pc_en), 32'd0);
         chk("t3_no_req", 32'(mem_req), 32'd0);
      end
      tick();
      PC_select = 1'b1;
      tgt       = 32'hA0;
      settle();
      chk("t3_next_addr", mem_addr, 32'h8);
      chk("t3_next_req", 32'(mem_req), 32'd1);
      chk("t3_cleared", instr, NOP_I);

      // Redirect while request pending: completion discarded, refetch at target.
      for (int i = 0; i < 3; i++) begin
         tick();
         PC_select = 1'b0;
         settle();
         chk("t4_addr_hold", mem_addr, 32'h8);
         chk("t4_req_hold", 32'(mem_req), 32'd1);
         chk("t4_no_valid", 32'(instr_valid), 32'd0);
      end
      tick();
      lat = 0;
      settle();
      chk("t4_new_addr", mem_addr, 32'hA0);
      chk("t4_new_req", 32'(mem_req), 32'd1);
      chk("t4_no_valid2", 32'(instr_valid), 32'd0);
      chk("t4_no_pc_en", 32'(pc_en), 32'd0);
      tick(); tick(); settle();
      chk("t4_valid", 32'(instr_valid), 32'd1);
      chk("t4_instr_pc", instr_pc, 32'hA0);
      chk("t4_instr", instr, memf(32'hA0));

      // Redirect and ready together in FULL: redirect wins.
      PC_select = 1'b1;
      tgt       = 32'h200;
      settle();
      chk("t5_pc_en_gated", 32'(pc_en), 32'd0);
      tick();
      PC_select = 1'b0;
      settle();
      chk("t5_dropped", 32'(instr_valid), 32'd0);
      chk("t5_nop", instr, NOP_I);
      chk("t5_no_req", 32'(mem_req), 32'd0);
      tick(); settle();
      chk("t5_req", 32'(mem_req), 32'd1);
      chk("t5_addr", mem_addr, 32'h200);
      tick(); settle();
      chk("t5_valid", 32'(instr_valid), 32'd1);
      chk("t5_instr_pc", instr_pc, 32'h200);

      // Misaligned target traps; a redirect to an aligned PC recovers.
      PC_select   = 1'b1;
      tgt         = 32'h202;
      instr_ready = 1'b0;
      tick();
      PC_select = 1'b0;
      settle();
      chk("t6_flush", 32'(instr_valid), 32'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         if (i == 2) begin
            PC_select = 1'b1;
            tgt       = 32'h200;
         end
         settle();
         chk("t6_misalign", 32'(fetch_misalign), 32'd1);
         chk("t6_no_req", 32'(mem_req), 32'd0);
      end
      tick();
      PC_select = 1'b0;
      settle();
      chk("t6_flag_clr", 32'(fetch_misalign), 32'd0);
      tick();
      instr_ready = 1'b1;
      settle();
      chk("t6_resume_req", 32'(mem_req), 32'd1);
      chk("t6_resume_addr", mem_addr, 32'h200);
      for (int i = 0; i < 10 && !instr_valid; i++) begin
         tick(); settle();
      end
      chk("t6_valid", 32'(instr_valid), 32'd1);
      chk("t6_instr_pc", instr_pc, 32'h200);
      chk("t6_instr", instr, memf(32'h200));

      // Random traffic against an instruction-stream model.
      exp_pc    = 32'h204;
      prev_wait = 1'b0;
      prev_addr = 32'h0;
      spur      = 1'b1;
      for (int n = 0; n < 800; n++) begin
         tick();
         if (n % 50 == 0) lat = $urandom_range(0, 3);
         instr_ready = ($urandom_range(0, 3) != 0);
         PC_select   = ($urandom_range(0, 11) == 0);
         tgt         = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
         settle();
         if (prev_wait) begin
            chk("rnd_req_hold", 32'(mem_req), 32'd1);
            chk("rnd_addr_hold", mem_addr, prev_addr);
         end
         if (!instr_valid) chk("rnd_nop", instr, NOP_I);
         if (PC_select) begin
            chk("rnd_pc_en_redirect", 32'(pc_en), 32'd0);
            exp_pc = tgt;
         end else if (instr_valid && instr_ready) begin
            chk("rnd_instr_pc", instr_pc, exp_pc);
            chk("rnd_instr", instr, memf(exp_pc));
            exp_pc = exp_pc + 32'd4;
            ndel++;
         end
         prev_wait = mem_req && !mem_ack;
         prev_addr = mem_addr;
      end
      chk("rnd_misalign", 32'(fetch_misalign), 32'd0);
      chk("rnd_progress", 32'(ndel >= 40), 32'd1);

      // Reset in the middle of a request abandons it at once.
      PC_select   = 1'b0;
      instr_ready = 1'b0;
      spur        = 1'b0;
      lat         = 3;
      for (int i = 0; i < 20 && !mem_req; i++) begin
         tick(); settle();
      end
      chk("rst_mid_pre", 32'(mem_req), 32'd1);
      rst_n = 1'b0;
      settle();
      chk("rst_mid_req", 32'(mem_req), 32'd0);
      chk("rst_mid_addr", mem_addr, 32'h0);
      chk("rst_mid_valid", 32'(instr_valid), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
